// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction RAM read port, redirect/stall controls and decode handshake.
interface inst_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_data;
  logic              ram_done;
  logic              redir;
  logic [ADDR_W-1:0] redir_pc;
  logic              stall;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic              id_ready;
  logic              if_err;

  modport master (
    output ram_re, ram_addr, if_valid, if_inst, if_pc, if_err,
    input  ram_data, ram_done, redir, redir_pc, stall, id_ready
  );

  modport slave (
    input  ram_re, ram_addr, if_valid, if_inst, if_pc, if_err,
    output ram_data, ram_done, redir, redir_pc, stall, id_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, one RAM word read per cycle, 2-entry output queue, redirect flush.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects instead of masking them.
//
// state | meaning
// IDLE  | first cycle after reset, no read
// FETCH | issue reads while queue has room, capture returned words
// FLUSH | one dead cycle after a redirect; held here while a misalign trap is pending
module inst_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2
) (
  input logic          clk,
  input logic          clr,
  inst_fetch_if.master bus
);
  localparam int            CW   = $clog2(QDEPTH + 1);
  localparam int            IW   = $clog2(QDEPTH);
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [CW-1:0]     cnt_q, cnt_nxt;
  logic [31:0]       q_inst     [QDEPTH];
  logic [31:0]       q_inst_nxt [QDEPTH];
  logic [ADDR_W-1:0] q_pc       [QDEPTH];
  logic [ADDR_W-1:0] q_pc_nxt   [QDEPTH];
  logic              valid;
  logic              issue;
  logic              pop;
  logic              push;
  logic              err_q;
  logic              tgt_bad;
  logic [ADDR_W-1:0] tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt     = bus.redir_pc;
  assign tgt_bad = |bus.redir_pc[1:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_q <= 1'b0;
    end else if (bus.redir) begin
      err_q <= tgt_bad;
    end
  end
`else
  assign tgt     = bus.redir_pc & ~ADDR_W'(3);
  assign tgt_bad = 1'b0;
  assign err_q   = 1'b0;
`endif

  assign valid        = (cnt_q != '0);
  assign pop          = valid & bus.id_ready & ~bus.stall;
  assign push         = issue & bus.ram_done;

  assign bus.ram_re   = issue;
  assign bus.ram_addr = pc_q;
  assign bus.if_valid = valid;
  assign bus.if_inst  = q_inst[0];
  assign bus.if_pc    = q_pc[0];
  assign bus.if_err   = err_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // A same-cycle pop frees the slot the returning word will land in.
  always_comb begin
    state_nxt = state_q;
    issue     = 1'b0;
    case (state_q)
      IDLE:    state_nxt = FETCH;
      FETCH:   issue = ~bus.stall & ((cnt_q < FULL) | pop);
      FLUSH:   if (!err_q) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
    if (bus.redir) begin
      state_nxt = FLUSH;
    end
  end

  always_comb begin
    q_inst_nxt = q_inst;
    q_pc_nxt   = q_pc;
    cnt_nxt    = cnt_q;
    pc_nxt     = pc_q;
    if (bus.redir) begin
      cnt_nxt = '0;
      pc_nxt  = tgt;
      if (tgt_bad) begin
        q_pc_nxt[0] = bus.redir_pc;
      end
    end else begin
      if (pop) begin
        for (int i = 0; i < QDEPTH - 1; i++) begin
          q_inst_nxt[i] = q_inst[i + 1];
          q_pc_nxt[i]   = q_pc[i + 1];
        end
        cnt_nxt = cnt_q - CW'(1);
      end
      if (push) begin
        q_inst_nxt[cnt_nxt[IW-1:0]] = bus.ram_data;
        q_pc_nxt[cnt_nxt[IW-1:0]]   = pc_q;
        cnt_nxt = cnt_nxt + CW'(1);
        pc_nxt  = pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      pc_q   <= pc_nxt;
      cnt_q  <= cnt_nxt;
      q_inst <= q_inst_nxt;
      q_pc   <= q_pc_nxt;
    end
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage of the multi-cycle/pipelined CPU; sits directly upstream of the instruction RAM and drives its read port.
- Holds the PC, issues one word read per cycle, and captures each returned word into a 2-entry output queue.
- Hands instructions to decode over a valid/ready handshake, and accepts branch/jump redirects that flush in-flight work.

Parameters:
- ADDR_W, 16, byte-address width of the instruction RAM read port; matches the RAM's address width.
- RESET_PC, 0, byte address fetched first after reset.
- QDEPTH, 2, output queue depth in entries; fixed at 2, no other value supported.

Ports:
- clk  in  1  system clock; RAM reads on negedge, this block on posedge
- clr  in  1  asynchronous active-high reset
- ram_re  out  1  RAM read enable
- ram_addr  out  ADDR_W  RAM byte read address (always PC)
- ram_data  in  32  RAM read data, little-endian word, updated on negedge
- ram_done  in  1  RAM read-finished flag
- redir  in  1  branch/jump taken, single-cycle pulse
- redir_pc  in  ADDR_W  redirect target byte address
- stall  in  1  global pipeline freeze; no fetch issue, no queue change
- if_valid  out  1  queue head holds a valid instruction
- if_inst  out  32  queue head instruction
- if_pc  out  ADDR_W  byte address of if_inst
- id_ready  in  1  decode consumes head when if_valid&id_ready
- if_err  out  1  misaligned fetch trap (optional feature only)

Behaviour:
- Reset, asynchronous while clr=1: pc=RESET_PC; queue empty; state=IDLE; ram_re=0; if_valid=0; if_inst=0; if_pc=0; if_err=0.
- Outputs are registered. ram_addr=pc combinationally from the register, so it is stable before the negedge.
- FSM states:
  - IDLE: entered from reset; goes to FETCH on the next clk.
  - FETCH: ram_re=1 unless stall or the queue is full, counting a same-cycle dequeue as freeing space.
  - FLUSH: ram_re=0 for exactly one cycle, clearing the stale ram_done; then FETCH.
- Capture rule: at posedge in FETCH, if ram_re was 1 for the whole cycle and ram_done=1, then push {ram_data, pc} and pc<=pc+4. Latency is 1 cycle from issue to capture; throughput is 1 word/cycle.
- ram_re=0 in a cycle means no capture and no pc change, even if ram_done=1.
- Queue:
  - 2-entry FIFO; head drives if_inst/if_pc; if_valid = not empty.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push while full cannot occur because issue is suppressed when full; a bench assertion checks this.
  - Pop while empty is ignored.
- Redirect, redir=1 at posedge (highest priority, overrides stall):
  - pc<=redir_pc; queue cleared; any capture that cycle is discarded; state<=FLUSH.
  - if_valid=0 from the next cycle.
- Stall=1: ram_re=0; pc and queue frozen; pop suppressed even if id_ready=1.
- pc wraps modulo 2^ADDR_W. No fetch is issued at an address within 3 bytes of the top of the RAM; the bench does not exercise that case.
- Reset mid-fetch: the in-flight word is lost; fetch restarts from RESET_PC via IDLE.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redir_pc[1:0]!=0 sets if_err=1 with if_pc=redir_pc and if_valid=0.
  - Fetch halts in FLUSH until the next valid redirect or reset.
  - if_err clears on the next aligned redirect.
- Undefined:
  - redir_pc[1:0] is forced to 0 on redirect.
  - if_err is tied to 0.

Test Plan:
- Reset with RESET_PC=0, RAM words 0x11111111, 0x22222222, 0x33333333, id_ready=1 -> ram_re high in cycle 2; if_inst=0x11111111 with if_pc=0, then 0x22222222/4 and 0x33333333/8 on consecutive cycles.
- id_ready=0 for 5 cycles after start -> queue fills with pc 0 and 4; ram_re drops; pc holds at 8. Raising id_ready -> words delivered in order with no loss or duplication.
- redir=1, redir_pc=0x40, while queue holds 2 entries -> next cycle if_valid=0 and one FLUSH cycle with ram_re=0. The following fetch uses ram_addr=0x40; first delivered if_pc=0x40.
- stall=1 for 3 cycles mid-stream with id_ready=1 -> if_pc, pc and queue unchanged; no pop. Releasing stall -> stream resumes at the next sequential pc.
- redir and stall asserted in the same cycle -> redirect taken: pc=redir_pc, queue cleared.
- With FETCH_ALIGN_CHECK_EN: redir_pc=0x42 -> if_err=1, if_pc=0x42, no further ram_re. A later redir_pc=0x80 clears if_err and fetch resumes at 0x80. Without the macro: redir_pc=0x42 fetches from 0x40.
